mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration of mult/multu in cycles (>=1).
REQ-002 Parameter DIV_CYCLES, default 10, busy duration of div/divu in cycles (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  E-stage MDU instruction valid this cycle.
REQ-006 op  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
REQ-007 A  input  32  rs operand (dividend / multiplicand / mthi-mtlo data).
REQ-008 B  input  32  rt operand (divisor / multiplier).
REQ-009 busy  output  1  multi-cycle operation in progress; fed to the stall unit.
REQ-010 HI  output  32  architectural HI register, read directly by mfhi.
REQ-011 LO  output  32  architectural LO register, read directly by mflo.

Function
REQ-012 State machine SHALL have exactly two states: IDLE (busy=0) and RUN (busy=1); busy is a register output.
REQ-013 IDLE, start=1, op in {mult,multu}: SHALL latch result into internal temp registers, load counter with MULT_CYCLES, enter RUN.
REQ-014 IDLE, start=1, op in {div,divu}: SHALL latch quotient/remainder into temp, load counter with DIV_CYCLES, enter RUN.
REQ-015 RUN: counter SHALL decrement each edge; on the edge where counter==1, SHALL write temp to HI/LO, clear busy, return to IDLE.
REQ-016 Consequence: start sampled at edge T -> busy high in cycles T+1..T+N exactly, new HI/LO visible from cycle T+N+1 with busy=0.
REQ-017 HI/LO SHALL remain unchanged throughout RUN; mfhi/mflo during RUN is prevented by the stall unit, not by this block.
REQ-018 mult: {HI,LO} = signed A * signed B (64-bit); multu: unsigned product.
REQ-019 div: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend; divu: unsigned quotient/remainder.
REQ-020 div 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000.
REQ-021 Divide by zero (B==0, div or divu): SHALL run full DIV_CYCLES busy, then leave HI and LO unchanged.
REQ-022 mthi: HI <= A at the sampling edge, LO unchanged, busy stays 0; mtlo symmetric on LO.
REQ-023 op none or reserved with start=1: no state change.
REQ-024 start=1 while busy=1: SHALL be ignored entirely (no restart, no HI/LO write, counter unaffected).
REQ-025 start=1 on the same edge busy falls (counter==1): the completing write SHALL occur; the new start is ignored (busy still 1 when sampled).
REQ-026 Operands SHALL be captured at the start edge; changes on A/B during RUN SHALL not affect the result.

Reset
REQ-027 reset low SHALL immediately (asynchronously) force busy=0, counter=0, HI=0, LO=0, temp=0, state IDLE.
REQ-028 reset asserted mid-RUN SHALL abort the operation; no result SHALL ever be written afterward.
REQ-029 After reset release, first start SHALL be accepted on the first rising edge with reset high.

Verification
REQ-030 mult A=0xFFFFFFFE (-2), B=3, start 1 cycle -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-032 div A=0xFFFFFFF9 (-7), B=2 -> busy exactly 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7,B=0 -> 10 busy cycles, HI/LO unchanged.
REQ-033 mthi A=0x12345678 then mtlo A=0x9ABCDEF0 on consecutive cycles -> HI=0x12345678, LO=0x9ABCDEF0, busy never asserted.
REQ-034 div started, reset pulsed low at busy cycle 4 -> busy=0, HI=LO=0 immediately and stay 0 past cycle 10.
REQ-035 start mult while busy from a div (including on the final busy cycle) -> ignored; HI/LO reflect only the div result.

Source files
------------

// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO registers. It computes the result at the start
// edge, then holds busy for a fixed cycle count before committing the result to HI/LO.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state_r, state_n;
    logic [31:0] cnt_r, cnt_n;
    logic        busy_r, busy_n;
    logic [31:0] hi_r, hi_n, lo_r, lo_n;
    logic [31:0] temp_hi_r, temp_hi_n, temp_lo_r, temp_lo_n;
    logic        temp_wr_r, temp_wr_n;

    logic signed [63:0] smul_s;
    logic        [63:0] umul_s;
    logic        [31:0] dvd_s, dvs_s, q_mag_s, r_mag_s, quot_s, rem_s;
    logic               neg_q_s, neg_r_s, is_sdiv_s;

    assign smul_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign umul_s = {32'd0, A} * {32'd0, B};

    // Signed divide runs on magnitudes so that 0x80000000 / -1 wraps cleanly instead of overflowing.
    assign is_sdiv_s = (op == OP_DIV);
    assign dvd_s     = (is_sdiv_s && A[31]) ? (32'd0 - A) : A;
    assign dvs_s     = (B == 32'd0) ? 32'd1 : ((is_sdiv_s && B[31]) ? (32'd0 - B) : B);
    assign q_mag_s   = dvd_s / dvs_s;
    assign r_mag_s   = dvd_s % dvs_s;
    assign neg_q_s   = is_sdiv_s && (A[31] ^ B[31]);
    assign neg_r_s   = is_sdiv_s && A[31];
    assign quot_s    = neg_q_s ? (32'd0 - q_mag_s) : q_mag_s;
    assign rem_s     = neg_r_s ? (32'd0 - r_mag_s) : r_mag_s;

    // State, counter, temp and architectural registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            cnt_r     <= 32'd0;
            busy_r    <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            temp_hi_r <= 32'd0;
            temp_lo_r <= 32'd0;
            temp_wr_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            cnt_r     <= cnt_n;
            busy_r    <= busy_n;
            hi_r      <= hi_n;
            lo_r      <= lo_n;
            temp_hi_r <= temp_hi_n;
            temp_lo_r <= temp_lo_n;
            temp_wr_r <= temp_wr_n;
        end
    end

    // Next-state logic: accept work only in IDLE, count down and commit in RUN.
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        busy_n    = busy_r;
        hi_n      = hi_r;
        lo_n      = lo_r;
        temp_hi_n = temp_hi_r;
        temp_lo_n = temp_lo_r;
        temp_wr_n = temp_wr_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            temp_hi_n = (op == OP_MULT) ? smul_s[63:32] : umul_s[63:32];
                            temp_lo_n = (op == OP_MULT) ? smul_s[31:0]  : umul_s[31:0];
                            temp_wr_n = 1'b1;
                            cnt_n     = 32'(MULT_CYCLES);
                            busy_n    = 1'b1;
                            state_n   = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            temp_hi_n = rem_s;
                            temp_lo_n = quot_s;
                            temp_wr_n = (B != 32'd0);
                            cnt_n     = 32'(DIV_CYCLES);
                            busy_n    = 1'b1;
                            state_n   = RUN;
                        end
                        OP_MTHI: hi_n = A;
                        OP_MTLO: lo_n = A;
                        default: state_n = IDLE;
                    endcase
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == 32'd1) begin
                    cnt_n   = 32'd0;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                    if (temp_wr_r) begin
                        hi_n = temp_hi_r;
                        lo_n = temp_lo_r;
                    end else begin
                        hi_n = hi_r;
                        lo_n = lo_r;
                    end
                end else begin
                    cnt_n = cnt_r - 32'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 32'd0;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign busy = busy_r;
    assign HI   = hi_r;
    assign LO   = lo_r;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: a cycle-level reference model compared every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    int checks = 0;
    int failures = 0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    // Reference model: pending result plus remaining busy cycles.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        p_wr;
    int          m_left;

    function automatic logic [64:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] t, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ref_result = 65'd0;
        case (o)
            3'd1: begin t = sa * sb; ref_result = {1'b1, t}; end
            3'd2: begin t = ua * ub; ref_result = {1'b1, t}; end
            3'd3: if (b != 32'd0) begin q = sa / sb; r = sa % sb; ref_result = {1'b1, r[31:0], q[31:0]}; end
            3'd4: if (b != 32'd0) begin q = ua / ub; r = ua % ub; ref_result = {1'b1, r[31:0], q[31:0]}; end
            default: ref_result = 65'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        logic [64:0] res;
        if (!reset) begin
            m_hi <= 32'd0; m_lo <= 32'd0; m_left <= 0;
            p_hi <= 32'd0; p_lo <= 32'd0; p_wr <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1 && p_wr) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
        end else if (start) begin
            res = ref_result(op, A, B);
            if (op == 3'd1 || op == 3'd2) begin
                m_left <= 5; p_wr <= res[64]; p_hi <= res[63:32]; p_lo <= res[31:0];
            end else if (op == 3'd3 || op == 3'd4) begin
                m_left <= 10; p_wr <= res[64]; p_hi <= res[63:32]; p_lo <= res[31:0];
            end else if (op == 3'd5) begin
                m_hi <= A;
            end else if (op == 3'd6) begin
                m_lo <= A;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        checks++;
        if (busy !== (m_left != 0)) begin
            failures++;
            $display("FAIL model_busy t=%0t got=%0b exp=%0b", $time, busy, (m_left != 0));
        end
        checks++;
        if (HI !== m_hi) begin
            failures++;
            $display("FAIL model_hi t=%0t got=%h exp=%h", $time, HI, m_hi);
        end
        checks++;
        if (LO !== m_lo) begin
            failures++;
            $display("FAIL model_lo t=%0t got=%h exp=%h", $time, LO, m_lo);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Issue one op, scramble operands during RUN, and count busy cycles.
    task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv, output int n);
        start = 1'b1; op = o; A = av; B = bv;
        tick();
        start = 1'b0; op = 3'd0; A = $urandom; B = $urandom;
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
    endtask

    int n;

    initial begin
        reset = 1'b0; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
        repeat (3) tick();
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        reset = 1'b1;
        tick();

        // mthi then mtlo on consecutive cycles
        start = 1'b1; op = 3'd5; A = 32'h12345678;
        tick();
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        op = 3'd6; A = 32'h9ABCDEF0;
        tick();
        start = 1'b0; op = 3'd0;
        chk("mt_hi", HI, 32'h12345678);
        chk("mt_lo", LO, 32'h9ABCDEF0);
        chk("mt_busy", {31'd0, busy}, 32'd0);

        run_op(3'd1, 32'hFFFFFFFE, 32'd3, n);
        chk("mult_cycles", n, 32'd5);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFFA);

        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
        chk("multu_cycles", n, 32'd5);
        chk("multu_hi", HI, 32'hFFFFFFFE);
        chk("multu_lo", LO, 32'h00000001);

        run_op(3'd3, 32'hFFFFFFF9, 32'd2, n);
        chk("div_cycles", n, 32'd10);
        chk("div_lo", LO, 32'hFFFFFFFD);
        chk("div_hi", HI, 32'hFFFFFFFF);

        run_op(3'd4, 32'd7, 32'd0, n);
        chk("divu0_cycles", n, 32'd10);
        chk("divu0_hi", HI, 32'hFFFFFFFF);
        chk("divu0_lo", LO, 32'hFFFFFFFD);

        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, n);
        chk("divovf_lo", LO, 32'h80000000);
        chk("divovf_hi", HI, 32'h00000000);

        run_op(3'd4, 32'd100, 32'd7, n);
        chk("divu_lo", LO, 32'd14);
        chk("divu_hi", HI, 32'd2);

        run_op(3'd1, 32'h7FFFFFFF, 32'h80000000, n);
        chk("multmix_hi", HI, 32'hC0000000);
        chk("multmix_lo", LO, 32'h80000000);

        // none / reserved ops change nothing
        start = 1'b1; op = 3'd0; A = 32'h11111111;
        tick();
        op = 3'd7;
        tick();
        start = 1'b0;
        chk("nop_hi", HI, 32'hC0000000);
        chk("nop_busy", {31'd0, busy}, 32'd0);

        // mult issued during div, including the final busy cycle, is ignored
        start = 1'b1; op = 3'd3; A = 32'hFFFFFF9C; B = 32'd7;
        tick();
        for (int k = 1; k <= 10; k++) begin
            if (k == 3 || k == 10) begin
                start = 1'b1; op = 3'd1; A = 32'd5; B = 32'd5;
            end else begin
                start = 1'b0; op = 3'd0;
            end
            tick();
        end
        start = 1'b0; op = 3'd0;
        chk("ovl_busy", {31'd0, busy}, 32'd0);
        chk("ovl_hi", HI, 32'hFFFFFFFE);
        chk("ovl_lo", LO, 32'hFFFFFFF2);
        tick();
        chk("ovl_busy2", {31'd0, busy}, 32'd0);

        // reset pulse mid-divide aborts it
        start = 1'b1; op = 3'd4; A = 32'd100; B = 32'd7;
        tick();
        start = 1'b0; op = 3'd0;
        repeat (3) tick();
        chk("abort_pre_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        #1 reset = 1'b1;
        repeat (12) tick();
        chk("abort_late_hi", HI, 32'd0);
        chk("abort_late_lo", LO, 32'd0);
        chk("abort_late_busy", {31'd0, busy}, 32'd0);

        // first edge after reset release accepts a start
        reset = 1'b0;
        #1;
        start = 1'b1; op = 3'd5; A = 32'hCAFEBABE;
        #1 reset = 1'b1;
        tick();
        start = 1'b0; op = 3'd0;
        chk("post_reset_hi", HI, 32'hCAFEBABE);
        chk("post_reset_lo", LO, 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
